// File: rtl/md_sched.sv
// md_sched: sequencing controller for the multiply/divide unit.
// Launches long HI/LO operations, counts down their fixed latency, commits
// results with HI/LO write pulses, stalls colliding D-stage MD instructions,
// and cancels in-flight work on flush. All outputs except stall_d are registered.
module md_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       e_valid,
    input  logic [3:0] e_op,
    input  logic       d_is_md,
    input  logic       flush,
    output logic       start,
    output logic [3:0] start_op,
    output logic       busy,
    output logic       stall_d,
    output logic       hi_we,
    output logic       lo_we,
    output logic [7:0] remain,
    output logic       drop
);

    localparam logic [7:0] MULT_N = 8'(MULT_CYCLES);
    localparam logic [7:0] DIV_N  = 8'(DIV_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // mult/multu/div/divu/madd/msub occupy the unit for a fixed latency
    function automatic logic is_long_op(input logic [3:0] op);
        case (op)
            4'd1, 4'd2, 4'd3, 4'd4, 4'd9, 4'd10: is_long_op = 1'b1;
            default:                             is_long_op = 1'b0;
        endcase
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        case (op)
            4'd3, 4'd4: is_div_op = 1'b1;
            default:    is_div_op = 1'b0;
        endcase
    endfunction

    // Codes 0 and 11..15 are no-ops and never cause a drop
    function automatic logic is_md_op(input logic [3:0] op);
        is_md_op = (op >= 4'd1) && (op <= 4'd10);
    endfunction

    state_t     state_r, state_nxt_s;
    logic [7:0] remain_r, remain_nxt_s;
    logic       start_r, start_nxt_s;
    logic [3:0] start_op_r, start_op_nxt_s;
    logic       busy_r, busy_nxt_s;
    logic       hi_we_r, hi_we_nxt_s;
    logic       lo_we_r, lo_we_nxt_s;
    logic       drop_r, drop_nxt_s;
    logic       ready_s;
    logic       accept_s;

    // The unit can take a new op in IDLE and in the single DONE cycle
    assign ready_s  = (state_r == ST_IDLE) || (state_r == ST_DONE);
    assign accept_s = e_valid & ~flush & ready_s;

    // State and countdown register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            remain_r <= 8'd0;
        end else begin
            state_r  <= state_nxt_s;
            remain_r <= remain_nxt_s;
        end
    end

    // Next-state and countdown: flush overrides everything but reset
    always_comb begin
        state_nxt_s  = state_r;
        remain_nxt_s = remain_r;
        if (flush) begin
            state_nxt_s  = ST_IDLE;
            remain_nxt_s = 8'd0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (e_valid && is_long_op(e_op)) begin
                        state_nxt_s  = ST_RUN;
                        remain_nxt_s = is_div_op(e_op) ? DIV_N : MULT_N;
                    end else begin
                        state_nxt_s  = ST_IDLE;
                        remain_nxt_s = 8'd0;
                    end
                end
                ST_RUN: begin
                    if (remain_r <= 8'd1) begin
                        state_nxt_s  = ST_DONE;
                        remain_nxt_s = 8'd0;
                    end else begin
                        state_nxt_s  = ST_RUN;
                        remain_nxt_s = remain_r - 8'd1;
                    end
                end
                default: begin
                    state_nxt_s  = ST_IDLE;
                    remain_nxt_s = 8'd0;
                end
            endcase
        end
    end

    // Next values of the registered outputs, derived from the upcoming state
    always_comb begin
        start_nxt_s    = accept_s & is_long_op(e_op);
        start_op_nxt_s = start_nxt_s ? e_op : start_op_r;
        busy_nxt_s     = (state_nxt_s == ST_RUN);
        hi_we_nxt_s    = (state_nxt_s == ST_DONE) | (accept_s & (e_op == 4'd7));
        lo_we_nxt_s    = (state_nxt_s == ST_DONE) | (accept_s & (e_op == 4'd8));
        drop_nxt_s     = e_valid & ~flush & (state_r == ST_RUN) & is_md_op(e_op);
    end

    // Output register bank
    always_ff @(posedge clk) begin
        if (reset) begin
            start_r    <= 1'b0;
            start_op_r <= 4'd0;
            busy_r     <= 1'b0;
            hi_we_r    <= 1'b0;
            lo_we_r    <= 1'b0;
            drop_r     <= 1'b0;
        end else begin
            start_r    <= start_nxt_s;
            start_op_r <= start_op_nxt_s;
            busy_r     <= busy_nxt_s;
            hi_we_r    <= hi_we_nxt_s;
            lo_we_r    <= lo_we_nxt_s;
            drop_r     <= drop_nxt_s;
        end
    end

    assign start    = start_r;
    assign start_op = start_op_r;
    assign busy     = busy_r;
    assign hi_we    = hi_we_r;
    assign lo_we    = lo_we_r;
    assign remain   = remain_r;
    assign drop     = drop_r;

    // Hold a D-stage MD instruction while the unit is, or is about to be, occupied
    assign stall_d = d_is_md & (busy_r | start_r | (e_valid & is_long_op(e_op)));

endmodule

// File: tb/tb_md_sched.sv
// Self-checking bench for md_sched: directed scenarios plus randomized traffic
// compared against a cycle-count reference model.
module tb_md_sched;

    localparam int MULT = 5;
    localparam int DIV  = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       e_valid = 1'b0;
    logic [3:0] e_op = 4'd0;
    logic       d_is_md = 1'b0;
    logic       flush = 1'b0;
    logic       start, busy, stall_d, hi_we, lo_we, drop;
    logic [3:0] start_op;
    logic [7:0] remain;

    int n_checks = 0;
    int n_fail   = 0;

    md_sched #(.MULT_CYCLES(MULT), .DIV_CYCLES(DIV)) dut (
        .clk(clk), .reset(reset), .e_valid(e_valid), .e_op(e_op),
        .d_is_md(d_is_md), .flush(flush), .start(start), .start_op(start_op),
        .busy(busy), .stall_d(stall_d), .hi_we(hi_we), .lo_we(lo_we),
        .remain(remain), .drop(drop)
    );

    always #5 clk = ~clk;

    // Observed registered outputs packed together
    logic [16:0] obs;
    assign obs = {start, start_op, busy, hi_we, lo_we, remain, drop};

    // Reference model: cycles left in the current operation plus this cycle's pulses
    int         m_left  = 0;
    bit         m_start = 1'b0, m_hi = 1'b0, m_lo = 1'b0, m_drop = 1'b0;
    logic [3:0] m_op    = 4'd0;

    function automatic bit long_op(input logic [3:0] op);
        return op inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd9, 4'd10};
    endfunction

    function automatic logic [16:0] exp_vec();
        return {m_start, m_op, (m_left > 0), m_hi, m_lo, 8'(m_left), m_drop};
    endfunction

    function automatic logic exp_stall();
        return d_is_md & ((m_left > 0) | m_start | (e_valid & long_op(e_op)));
    endfunction

    // Advance the model with the inputs currently applied, then clock the DUT
    task automatic tick();
        bit running, commit;
        if (reset) begin
            m_left = 0; m_start = 0; m_hi = 0; m_lo = 0; m_drop = 0; m_op = 4'd0;
        end else if (flush) begin
            m_left = 0; m_start = 0; m_hi = 0; m_lo = 0; m_drop = 0;
        end else begin
            running = (m_left > 0);
            commit  = running && (m_left == 1);
            m_start = !running && e_valid && long_op(e_op);
            m_drop  = running && e_valid && (e_op >= 4'd1) && (e_op <= 4'd10);
            if (m_start) m_op = e_op;
            if (running) m_left = m_left - 1;
            else if (m_start) m_left = (e_op == 4'd3 || e_op == 4'd4) ? DIV : MULT;
            m_hi = commit || (!running && e_valid && e_op == 4'd7);
            m_lo = commit || (!running && e_valid && e_op == 4'd8);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset = 1'b0; e_valid = 1'b0; e_op = 4'd0; d_is_md = 1'b0; flush = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        n_checks++;
        if (obs !== 17'd0) begin
            n_fail++; $display("FAIL reset_outputs: got %h expected %h", obs, 17'd0);
        end
        #1;
        n_checks++;
        if (stall_d !== 1'b0) begin
            n_fail++; $display("FAIL reset_stall: got %b expected 0", stall_d);
        end
    endtask

    task automatic test_mult();
        do_reset();
        e_valid = 1'b1; e_op = 4'd1;
        tick();
        idle_inputs();
        for (int k = 1; k <= MULT + 1; k++) begin
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL mult_model c%0d: got %h expected %h", k, obs, exp_vec());
            end
            if (k <= MULT) begin
                n_checks++;
                if (remain !== 8'(MULT + 1 - k) || busy !== 1'b1 || start !== (k == 1)) begin
                    n_fail++; $display("FAIL mult_countdown c%0d: got remain=%0d busy=%b start=%b expected remain=%0d busy=1 start=%b",
                                       k, remain, busy, start, MULT + 1 - k, (k == 1));
                end
            end else begin
                n_checks++;
                if ({hi_we, lo_we, busy, remain} !== {1'b1, 1'b1, 1'b0, 8'd0}) begin
                    n_fail++; $display("FAIL mult_commit: got hi=%b lo=%b busy=%b remain=%0d expected 1 1 0 0",
                                       hi_we, lo_we, busy, remain);
                end
            end
            tick();
        end
    endtask

    task automatic test_div_stall();
        do_reset();
        d_is_md = 1'b1; e_valid = 1'b1; e_op = 4'd3;
        #1;
        n_checks++;
        if (stall_d !== 1'b1) begin
            n_fail++; $display("FAIL div_stall_accept: got %b expected 1", stall_d);
        end
        tick();
        e_valid = 1'b0;
        for (int k = 1; k <= DIV; k++) begin
            #1;
            n_checks++;
            if (stall_d !== 1'b1 || obs !== exp_vec()) begin
                n_fail++; $display("FAIL div_stall_run c%0d: got stall=%b out=%h expected stall=1 out=%h",
                                   k, stall_d, obs, exp_vec());
            end
            tick();
        end
        // DONE cycle: no stall when nothing long waits in E, then relaunch
        #1;
        n_checks++;
        if (stall_d !== 1'b0 || hi_we !== 1'b1 || lo_we !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL div_done: got stall=%b hi=%b lo=%b busy=%b expected 0 1 1 0",
                               stall_d, hi_we, lo_we, busy);
        end
        e_valid = 1'b1; e_op = 4'd3;
        tick();
        idle_inputs();
        n_checks++;
        if (start !== 1'b1 || remain !== 8'(DIV) || start_op !== 4'd3) begin
            n_fail++; $display("FAIL div_relaunch: got start=%b remain=%0d op=%0d expected 1 %0d 3",
                               start, remain, start_op, DIV);
        end
    endtask

    task automatic test_mt();
        do_reset();
        e_valid = 1'b1; e_op = 4'd7;
        tick();
        e_op = 4'd8;
        n_checks++;
        if ({hi_we, lo_we, busy, start} !== 4'b1000) begin
            n_fail++; $display("FAIL mthi: got %b expected 1000", {hi_we, lo_we, busy, start});
        end
        tick();
        idle_inputs();
        n_checks++;
        if ({hi_we, lo_we, busy, start} !== 4'b0100) begin
            n_fail++; $display("FAIL mtlo: got %b expected 0100", {hi_we, lo_we, busy, start});
        end
        d_is_md = 1'b1;
        tick();
        n_checks++;
        if (obs !== exp_vec() || stall_d !== 1'b0) begin
            n_fail++; $display("FAIL mt_after: got %h stall=%b expected %h stall=0", obs, stall_d, exp_vec());
        end
        d_is_md = 1'b0;
    endtask

    task automatic test_flush();
        do_reset();
        e_valid = 1'b1; e_op = 4'd4;
        tick();                  // T+1
        idle_inputs();
        tick(); tick();          // T+3
        flush = 1'b1;
        tick();                  // T+4
        flush = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || remain !== 8'd0 || hi_we !== 1'b0) begin
            n_fail++; $display("FAIL flush_cancel: got busy=%b remain=%0d hi=%b expected 0 0 0", busy, remain, hi_we);
        end
        e_valid = 1'b1; e_op = 4'd1;
        tick();                  // T+5
        idle_inputs();
        n_checks++;
        if (start !== 1'b1 || start_op !== 4'd1) begin
            n_fail++; $display("FAIL flush_newmult: got start=%b op=%0d expected 1 1", start, start_op);
        end
        for (int t = 6; t <= 11; t++) begin
            tick();
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL flush_follow T+%0d: got %h expected %h", t, obs, exp_vec());
            end
        end
        n_checks++;
        if (hi_we !== 1'b0 || lo_we !== 1'b0) begin
            n_fail++; $display("FAIL flush_nowrite: got hi=%b lo=%b expected 0 0", hi_we, lo_we);
        end
    endtask

    task automatic test_drop();
        do_reset();
        e_valid = 1'b1; e_op = 4'd2;
        tick();                  // T+1, remain=MULT
        tick();                  // T+2, multu during RUN
        idle_inputs();
        n_checks++;
        if (drop !== 1'b1 || start !== 1'b0 || remain !== 8'(MULT - 1)) begin
            n_fail++; $display("FAIL drop_pulse: got drop=%b start=%b remain=%0d expected 1 0 %0d",
                               drop, start, remain, MULT - 1);
        end
        tick();
        n_checks++;
        if (drop !== 1'b0 || remain !== 8'(MULT - 2)) begin
            n_fail++; $display("FAIL drop_clear: got drop=%b remain=%0d expected 0 %0d", drop, remain, MULT - 2);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        e_valid = 1'b1; e_op = 4'd9;
        tick();
        idle_inputs();
        tick();                  // T+2
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if (obs !== 17'd0) begin
            n_fail++; $display("FAIL reset_mid: got %h expected %h", obs, 17'd0);
        end
        e_valid = 1'b1; e_op = 4'd12;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if (obs !== 17'd0) begin
                n_fail++; $display("FAIL noop_code c%0d: got %h expected %h", k, obs, 17'd0);
            end
        end
        idle_inputs();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 800; c++) begin
            e_valid = ($urandom_range(0, 1) == 1);
            e_op    = 4'($urandom_range(0, 15));
            d_is_md = ($urandom_range(0, 2) == 0);
            flush   = ($urandom_range(0, 24) == 0);
            reset   = ($urandom_range(0, 99) == 0);
            #1;
            n_checks++;
            if (stall_d !== exp_stall()) begin
                n_fail++; $display("FAIL rand_stall c%0d: got %b expected %b", c, stall_d, exp_stall());
            end
            tick();
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL rand_out c%0d: got %h expected %h", c, obs, exp_vec());
            end
        end
        idle_inputs();
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_mult();
        test_div_stall();
        test_mt();
        test_flush();
        test_drop();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/md_sched.md
# md_sched

Sequencing controller for the multiply/divide unit of the P6 five-stage pipeline. Accepts one HI/LO operation per cycle from the E stage and launches it on the multiply/divide datapath. Holds the unit busy for the fixed multiply or divide latency and drives the D-stage stall for any HI/LO-touching instruction that would collide. Commits results to HI/LO with explicit write pulses, and cancels in-flight work on a pipeline flush.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu/madd/msub (1..255)
- DIV_CYCLES, 10, busy cycles for div/divu (1..255)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- e_valid  in  1  E-stage holds an MD instruction this cycle
- e_op  in  4  1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9 madd, 10 msub; others = no-op
- d_is_md  in  1  D-stage instruction is any of op codes 1..10
- flush  in  1  pipeline flush; cancels the in-flight operation
- start  out  1  one-cycle launch pulse to the datapath, registered
- start_op  out  4  op code latched at launch; holds until the next launch
- busy  out  1  operation in flight
- stall_d  out  1  freeze F/D, insert bubble into E
- hi_we  out  1  one-cycle HI commit pulse
- lo_we  out  1  one-cycle LO commit pulse
- remain  out  8  cycles left in the current operation
- drop  out  1  pulse: E-stage op arrived while busy and was discarded

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - e_valid with a long op (1,2,3,4,9,10) and no flush: next cycle start=1, start_op=e_op, remain=MULT_CYCLES or DIV_CYCLES, state RUN.
  - e_valid with op 7 (mthi): next cycle hi_we=1 only; state stays IDLE, no busy.
  - e_valid with op 8 (mtlo): next cycle lo_we=1 only; state stays IDLE, no busy.
  - Ops 5, 6 and no-op codes: no effect on state or outputs.
- RUN:
  - remain decrements by 1 each cycle.
  - When remain reaches 1: next state DONE, remain=0.
  - busy=1 throughout RUN.
- DONE: lasts exactly one cycle. hi_we=lo_we=1, busy=0, then state IDLE. A long op accepted in that same cycle launches normally, giving back-to-back operation.
- e_valid while in RUN: op ignored, drop=1 next cycle, state unchanged.
- stall_d = d_is_md & (busy | start | (e_valid & e_op is a long op)). Combinational; this is the only combinational output.
- flush:
  - In any state: return to IDLE next cycle; remain=0; busy=0; no hi_we/lo_we for the cancelled op.
  - An E op presented in the same cycle as flush is discarded.
- Code 0 and codes 11..15 never start, write, or drop.
- madd/msub follow the MULT_CYCLES timing; accumulation is the datapath's job.

## Timing
- All registered outputs are 0 after reset; state=IDLE; start_op=0.
- Long op accepted at edge T: start=1 in cycle T+1; busy high in cycles T+1..T+N, where N is the parameter value.
  - remain reads N at T+1 and 1 at T+N.
  - DONE is in cycle T+N+1, with hi_we=lo_we=1 and busy=0.
- mthi/mtlo accepted at T: write pulse in T+1.
- Latency to commit: N+1 cycles after acceptance.
- Reset has priority over flush; flush has priority over e_valid.
- Reset asserted mid-RUN: next cycle fully idle, no write pulses.
- remain width is 8 bits. Parameters above 255 are illegal; parameters equal to 1 go RUN → DONE after a single busy cycle.

## Test plan
- Reset, then mult at T: start at T+1, busy T+1..T+5, remain 5,4,3,2,1, hi_we=lo_we=1 at T+6.
- div followed by d_is_md=1 held: stall_d=1 from acceptance through T+10, 0 in DONE; div in DONE cycle relaunches with start at T+12.
- mthi then mtlo in consecutive cycles: hi_we at T+1, lo_we at T+2, busy stays 0, stall_d 0 unless d_is_md during e_valid long op.
- flush at T+3 of divu: busy 0 at T+4, no hi_we/lo_we ever, new mult at T+4 launches at T+5.
- multu issued during RUN: drop=1 next cycle, remain countdown unaffected.
- Reset at T+2 of madd: all outputs 0 next cycle; op code 12 afterwards produces no start, write, or drop.
